reg_writeback_queue: RTL and testbench
======================================

// Module: reg_writeback_queue
// PURPOSE
//  Write-side initiator for the CPU register file's single write port.
//  - Sits between the MEM/WB pipeline stage and the register file.
//  - Accepts retiring instructions that request an rd write, a jal link write (r31), or both.
//  - Serialises those requests into at most one register-file write per cycle through a small FIFO.
//  - Exposes a bypass query port so decode can forward values still pending in the queue.
// PARAMETERS
//  DEPTH  4   FIFO entries; power of two, >= 2
//  AW     5   register address width
//  DW     32  register data width
// PORTS
//  CLK          in   1   clock; all state updates on posedge
//  Reset        in   1   reset, synchronous, active-high
//  in_valid     in   1   retiring instruction present
//  in_ready     out  1   unit can accept; = (count <= DEPTH-2), registered-state only
//  in_wr_en     in   1   instruction writes rd
//  in_rd        in   AW  destination register
//  in_data      in   DW  rd write value
//  in_is_jal    in   1   instruction writes link register r31
//  in_link      in   DW  link value (return address)
//  rf_we        out  1   register-file write strobe (registered)
//  rf_waddr     out  AW  register-file write address (registered)
//  rf_wdata     out  DW  register-file write data (registered)
//  q_addr       in   AW  bypass query address
//  q_hit        out  1   pending, uncommitted write to q_addr exists
//  q_data       out  DW  youngest pending value for q_addr
//  busy         out  1   = !empty | rf_we
// BEHAVIOUR
//  Accept
//  - Transfer occurs when in_valid & in_ready on posedge.
//  - rd entry is enqueued if in_wr_en & in_rd!=0. Writes to r0 are silently dropped.
//  - Link entry {31,in_link} is enqueued if in_is_jal.
//  - If both are enqueued, the rd entry goes first and the link entry second.
//    Consequence: with in_rd==31 the link value wins in the register file.
//  - in_ready guarantees room for 2 entries. No overflow is possible.
//  Drain
//  - Each posedge with the queue non-empty: pop the head into rf_waddr/rf_wdata and set rf_we<=1.
//  - If the queue is empty at the posedge: rf_we<=0. rf_waddr/rf_wdata hold their values.
//  - An entry enqueued on edge N is popped no earlier than edge N+1.
//    No same-edge bypass into the rf_* registers.
//  - Latency: accept on edge N into an empty queue -> rf_we high during cycle after edge N+1.
//  - The second entry of a dual write follows one cycle later.
//  - Simultaneous push and pop on the same edge is legal; count changes by (pushes - 1).
//  - Pointers wrap modulo DEPTH. count ranges 0..DEPTH.
//  Bypass (combinational)
//  - Search the in-flight rf_* register (if rf_we) plus all valid queue entries.
//  - The youngest match wins: tail-most queue entry, then rf_* register.
//  - q_addr==0 -> q_hit=0, q_data=0.
//  - No match -> q_hit=0, q_data=0.
//  Reset
//  - Takes effect at any time, including mid-drain.
//  - Flushes the queue: pointers=0, count=0.
//  - rf_we=0, rf_waddr=0, rf_wdata=0.
//  - Pending writes are discarded, not committed.
//  - in_ready=1 in the cycle after reset. Inputs are ignored while Reset=1.
// TESTING
//  1. Reset, then single push rd=5 data=0x1234 wr_en=1 -> one edge later rf_we=1, waddr=5, wdata=0x1234 for exactly 1 cycle; busy then falls.
//  2. jal with wr_en=1 rd=31 data=0xAAAA link=0x0040 -> rf writes (31,0xAAAA) then (31,0x0040) on consecutive cycles.
//  3. Push rd=0 data=0xFFFF wr_en=1 is_jal=0 -> no rf_we ever; q_hit(0)=0.
//  4. Back-to-back dual writes with DEPTH=4 -> in_ready drops at count 3; all entries drain in order; no loss or duplication across pointer wrap.
//  5. Queue holds r7=1 then r7=2, q_addr=7 -> q_hit=1, q_data=2. After both drain -> q_hit=0.
//  6. Assert Reset with 3 entries pending -> next cycle rf_we=0, busy=0, in_ready=1; the discarded entries never appear on rf_*.

Source files
------------

// File: rtl/reg_writeback_queue_if.sv
// Bundle between the MEM/WB stage, the register-file write port and the decode bypass query.
// The master modport drives retiring instructions and queries; the slave modport is the queue.
interface reg_writeback_queue_if #(
    parameter int AW = 5,
    parameter int DW = 32
);
    logic          in_valid;
    logic          in_ready;
    logic          in_wr_en;
    logic [AW-1:0] in_rd;
    logic [DW-1:0] in_data;
    logic          in_is_jal;
    logic [DW-1:0] in_link;
    logic          rf_we;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;
    logic [AW-1:0] q_addr;
    logic          q_hit;
    logic [DW-1:0] q_data;
    logic          busy;

    modport master (
        output in_valid, in_wr_en, in_rd, in_data, in_is_jal, in_link, q_addr,
        input  in_ready, rf_we, rf_waddr, rf_wdata, q_hit, q_data, busy
    );

    modport slave (
        input  in_valid, in_wr_en, in_rd, in_data, in_is_jal, in_link, q_addr,
        output in_ready, rf_we, rf_waddr, rf_wdata, q_hit, q_data, busy
    );
endinterface

// File: rtl/reg_writeback_queue.sv
// Serialises rd/link writes into one register-file write per cycle; accept-to-rf_we is 2 edges.
// Backpressure: in_ready only while room for two entries remains, so a dual write never overflows.
module reg_writeback_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic                  CLK,
    input  logic                  Reset,
    reg_writeback_queue_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);

    typedef logic [PW-1:0] ptr_t;
    typedef logic [PW:0]   cnt_t;

    localparam logic [AW-1:0] LINK_REG = AW'(31);

    logic [AW-1:0] entAddr [DEPTH];
    logic [DW-1:0] entData [DEPTH];
    ptr_t          headPtr;
    ptr_t          tailPtr;
    cnt_t          count;

    logic          accept;
    logic          pushRd;
    logic          pushLink;
    logic [1:0]    numPush;
    logic          doPop;

    assign bus.in_ready = (count <= cnt_t'(DEPTH - 2));
    assign accept       = bus.in_valid & bus.in_ready;
    assign pushRd       = accept & bus.in_wr_en & (bus.in_rd != '0);
    assign pushLink     = accept & bus.in_is_jal;
    assign numPush      = {1'b0, pushRd} + {1'b0, pushLink};
    assign doPop        = (count != '0);
    assign bus.busy     = doPop | bus.rf_we;

    always_ff @(posedge CLK) begin
        if (Reset) begin
            headPtr      <= '0;
            tailPtr      <= '0;
            count        <= '0;
            bus.rf_we    <= 1'b0;
            bus.rf_waddr <= '0;
            bus.rf_wdata <= '0;
        end else begin
            // Pop reads the pre-edge head, so an entry pushed this edge waits one more cycle.
            bus.rf_we <= doPop;
            if (doPop) begin
                bus.rf_waddr <= entAddr[headPtr];
                bus.rf_wdata <= entData[headPtr];
                headPtr      <= headPtr + ptr_t'(1);
            end
            if (pushRd) begin
                entAddr[tailPtr] <= bus.in_rd;
                entData[tailPtr] <= bus.in_data;
            end
            // Link goes behind rd so a jal with rd==31 commits the link value last.
            if (pushLink) begin
                entAddr[tailPtr + ptr_t'(pushRd)] <= LINK_REG;
                entData[tailPtr + ptr_t'(pushRd)] <= bus.in_link;
            end
            tailPtr <= tailPtr + ptr_t'(numPush);
            count   <= count + cnt_t'(numPush) - cnt_t'(doPop);
        end
    end

    ptr_t          scanIdx;
    logic          hitAcc;
    logic [DW-1:0] dataAcc;

    // Scan oldest to youngest so later matches override earlier ones.
    always_comb begin
        scanIdx = headPtr;
        hitAcc  = 1'b0;
        dataAcc = '0;
        if (bus.rf_we && (bus.rf_waddr == bus.q_addr)) begin
            hitAcc  = 1'b1;
            dataAcc = bus.rf_wdata;
        end
        for (int i = 0; i < DEPTH; i++) begin
            scanIdx = headPtr + ptr_t'(i);
            if ((cnt_t'(i) < count) && (entAddr[scanIdx] == bus.q_addr)) begin
                hitAcc  = 1'b1;
                dataAcc = entData[scanIdx];
            end
        end
        if (bus.q_addr == '0) begin
            hitAcc  = 1'b0;
            dataAcc = '0;
        end
    end

    assign bus.q_hit  = hitAcc;
    assign bus.q_data = dataAcc;
endmodule

// File: tb/tb_reg_writeback_queue.sv
// Randomised bench: a queue model of pending writes feeds a scoreboard drained by an rf monitor.
module tb_reg_writeback_queue;
    localparam int DEPTH = 4;
    localparam int AW    = 5;
    localparam int DW    = 32;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } ent_t;

    logic CLK   = 1'b0;
    logic Reset = 1'b1;
    always #5 CLK = ~CLK;

    reg_writeback_queue_if #(.AW(AW), .DW(DW)) bus ();

    reg_writeback_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .CLK   (CLK),
        .Reset (Reset),
        .bus   (bus)
    );

    ent_t expQ[$];
    bit   expWeNext = 1'b0;
    ent_t headEntry = '0;
    int   nChk = 0;
    int   nErr = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nChk++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Writes appear in acceptance order, one per cycle, exactly when the model had something queued.
    initial begin
        ent_t e;
        forever begin
            @(negedge CLK);
            chk("rf_we", bus.rf_we, expWeNext);
            if (bus.rf_we && expWeNext && expQ.size() > 0) begin
                e = expQ.pop_front();
                chk("rf_waddr", bus.rf_waddr, e.a);
                chk("rf_wdata", bus.rf_wdata, e.d);
            end
        end
    end

    task automatic cycle(input bit v, input bit we, input int rd, input logic [DW-1:0] dat,
                         input bit jal, input logic [DW-1:0] lnk, input int qa);
        ent_t          cur;
        bit            curWe;
        bit            hit;
        logic [DW-1:0] hd;
        bit            acc;
        @(negedge CLK);
        #1;
        curWe = expWeNext;
        cur   = headEntry;
        chk("in_ready", bus.in_ready, expQ.size() <= DEPTH - 2);
        chk("busy", bus.busy, (expQ.size() != 0) || curWe);
        bus.in_valid  = v;
        bus.in_wr_en  = we;
        bus.in_rd     = AW'(rd);
        bus.in_data   = dat;
        bus.in_is_jal = jal;
        bus.in_link   = lnk;
        bus.q_addr    = AW'(qa);
        #1;
        hit = 1'b0;
        hd  = '0;
        if (AW'(qa) != '0) begin
            if (curWe && cur.a == AW'(qa)) begin
                hit = 1'b1;
                hd  = cur.d;
            end
            foreach (expQ[i]) begin
                if (expQ[i].a == AW'(qa)) begin
                    hit = 1'b1;
                    hd  = expQ[i].d;
                end
            end
        end
        chk("q_hit", bus.q_hit, hit);
        chk("q_data", bus.q_data, hd);
        acc       = v && (expQ.size() <= DEPTH - 2);
        expWeNext = (expQ.size() != 0);
        if (expWeNext) headEntry = expQ[0];
        if (acc && we && AW'(rd) != '0) expQ.push_back(ent_t'{a: AW'(rd), d: dat});
        if (acc && jal) expQ.push_back(ent_t'{a: AW'(31), d: lnk});
    endtask

    task automatic idle(input int n, input int qa);
        for (int k = 0; k < n; k++) cycle(0, 0, 0, '0, 0, '0, qa);
    endtask

    task automatic doReset();
        @(negedge CLK);
        #1;
        Reset         = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_wr_en  = 1'b1;
        bus.in_rd     = AW'($urandom_range(1, 31));
        bus.in_data   = $urandom;
        bus.in_is_jal = 1'b1;
        bus.in_link   = $urandom;
        expQ.delete();
        expWeNext = 1'b0;
        @(negedge CLK);
        #1;
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_in_ready", bus.in_ready, 1'b1);
        chk("rst_waddr", bus.rf_waddr, '0);
        chk("rst_wdata", bus.rf_wdata, '0);
        Reset        = 1'b0;
        bus.in_valid = 1'b0;
    endtask

    function automatic int randReg();
        int r;
        r = int'($urandom_range(0, 9));
        return (r > 7) ? 31 : r;
    endfunction

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_wr_en  = 1'b0;
        bus.in_rd     = '0;
        bus.in_data   = '0;
        bus.in_is_jal = 1'b0;
        bus.in_link   = '0;
        bus.q_addr    = '0;
        doReset();

        cycle(1, 1, 5, 32'h1234, 0, '0, 5);
        idle(3, 5);
        cycle(1, 1, 31, 32'hAAAA, 1, 32'h0040, 31);
        idle(4, 31);
        cycle(1, 1, 0, 32'hFFFF, 0, '0, 0);
        idle(3, 0);
        cycle(1, 1, 7, 32'h1, 0, '0, 7);
        cycle(1, 1, 7, 32'h2, 0, '0, 7);
        idle(4, 7);

        for (int k = 0; k < 12; k++)
            cycle(1, 1, int'($urandom_range(1, 30)), $urandom, 1, $urandom, randReg());
        idle(10, 31);

        for (int k = 0; k < 3; k++)
            cycle(1, 1, 3 + k, $urandom, 1, $urandom, 31);
        doReset();
        idle(4, 3);

        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 199) == 0) doReset();
            else cycle(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), randReg(),
                       $urandom, bit'($urandom_range(0, 3) == 0), $urandom, randReg());
        end
        idle(10, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nChk, nErr);
        $finish;
    end
endmodule
